// File: rtl/rv32i_pkg.sv
// Shared RV32I multicycle-control definitions: opcodes, select encodings
// and the main controller state set. The immSrc encoding is shared with the
// immediate extender. Build option JALR_EN adds the two jalr states.
package rv32i_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RS1   = 2'b10
    } alu_src_a_e;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } alu_src_b_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [1:0] {
        RES_ALUOUT = 2'b00,
        RES_RDATA  = 2'b01,
        RES_ALURES = 2'b10
    } result_src_e;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_ERROR
`ifdef JALR_EN
        , S_JALR_CALC,
        S_JALR_JMP
`endif
    } state_e;

endpackage

// File: rtl/main_fsm_imm_dec.sv
// Immediate-format decoder: selects the extender format from the opcode alone.
module imm_dec
    import rv32i_pkg::*;
(
    input  logic [6:0] opcode_i,
    output logic [1:0] imm_src_o
);

    // Opcode to immediate format; unknown opcodes fall back to I-type
    always_comb begin
        case (opcode_i)
            OP_STORE:  imm_src_o = IMM_S;
            OP_BRANCH: imm_src_o = IMM_B;
            OP_JAL:    imm_src_o = IMM_J;
            default:   imm_src_o = IMM_I;
        endcase
    end

endmodule

// File: rtl/main_fsm.sv
// Multicycle RV32I main controller (Moore FSM). Define JALR_EN to add
// jalr support through the JALR_CALC / JALR_JMP states; otherwise jalr
// is treated as an unsupported instruction.
module main_fsm
    import rv32i_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       memReady,
    output logic [1:0] immSrc,
    output logic [1:0] aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluOp,
    output logic [1:0] resultSrc,
    output logic       adrSrc,
    output logic       irWrite,
    output logic       pcWrite,
    output logic       regWrite,
    output logic       memWrite,
    output logic       illegal
);

    state_e state_q, state_d;
    logic   ir_w, pc_w, reg_w, mem_w;

    imm_dec u_imm_dec (
        .opcode_i  (opcode),
        .imm_src_o (immSrc)
    );

    // State register; reset returns to FETCH immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (memReady) state_d = S_DECODE;
            S_DECODE: begin
                if (opcode == OP_LOAD || opcode == OP_STORE)  state_d = S_MEMADR;
                else if (opcode == OP_RTYPE)                  state_d = S_EXECR;
                else if (opcode == OP_ITYPE)                  state_d = S_EXECI;
                else if (opcode == OP_JAL)                    state_d = S_JAL;
                else if (opcode == OP_BRANCH &&
                         (funct3 == F3_BEQ || funct3 == F3_BNE)) state_d = S_BRANCH;
`ifdef JALR_EN
                else if (opcode == OP_JALR)                   state_d = S_JALR_CALC;
`endif
                else                                          state_d = S_ERROR;
            end
            S_MEMADR:   state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (memReady) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (memReady) state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_ERROR:    state_d = S_ERROR;
`ifdef JALR_EN
            S_JALR_CALC: state_d = S_JALR_JMP;
            S_JALR_JMP:  state_d = S_ALUWB;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    // Output decode from state; only FETCH and BRANCH strobes look at inputs
    always_comb begin
        aluSrcA   = SRCA_PC;
        aluSrcB   = SRCB_RS2;
        aluOp     = ALUOP_ADD;
        resultSrc = RES_ALUOUT;
        adrSrc    = 1'b0;
        ir_w      = 1'b0;
        pc_w      = 1'b0;
        reg_w     = 1'b0;
        mem_w     = 1'b0;
        case (state_q)
            S_FETCH: begin
                aluSrcB   = SRCB_FOUR;
                resultSrc = RES_ALURES;
                ir_w      = memReady;
                pc_w      = memReady;
            end
            S_DECODE: begin
                aluSrcA = SRCA_OLDPC;
                aluSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                aluSrcA = SRCA_RS1;
                aluSrcB = SRCB_IMM;
            end
            S_MEMREAD:  adrSrc = 1'b1;
            S_MEMWB: begin
                resultSrc = RES_RDATA;
                reg_w     = 1'b1;
            end
            S_MEMWRITE: begin
                adrSrc = 1'b1;
                mem_w  = 1'b1;
            end
            S_EXECR: begin
                aluSrcA = SRCA_RS1;
                aluOp   = ALUOP_FUNCT;
            end
            S_EXECI: begin
                aluSrcA = SRCA_RS1;
                aluSrcB = SRCB_IMM;
                aluOp   = ALUOP_FUNCT;
            end
            S_ALUWB:    reg_w = 1'b1;
            S_BRANCH: begin
                aluSrcA = SRCA_RS1;
                aluOp   = ALUOP_SUB;
                pc_w    = (funct3 == F3_BNE) ? ~zero : zero;
            end
            S_JAL: begin
                aluSrcA = SRCA_OLDPC;
                aluSrcB = SRCB_FOUR;
                pc_w    = 1'b1;
            end
`ifdef JALR_EN
            S_JALR_CALC: begin
                aluSrcA = SRCA_RS1;
                aluSrcB = SRCB_IMM;
            end
            S_JALR_JMP: begin
                aluSrcA = SRCA_OLDPC;
                aluSrcB = SRCB_FOUR;
                pc_w    = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Strobes are held low while reset is asserted, even if memReady is high
    assign irWrite  = ir_w  & rst_n;
    assign pcWrite  = pc_w  & rst_n;
    assign regWrite = reg_w & rst_n;
    assign memWrite = mem_w & rst_n;
    assign illegal  = (state_q == S_ERROR);

endmodule

// File: tb/tb_main_fsm.sv
// Self-checking bench for main_fsm: directed scenarios plus randomized
// instruction streams compared cycle by cycle against a per-instruction
// phase list derived from the controller's behavioural description.
module tb_main_fsm;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                           IT = 7'b0010011, JAL = 7'b1101111, BR = 7'b1100011,
                           JALR = 7'b1100111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       zero, memReady;
    logic [1:0] immSrc, aluSrcA, aluSrcB, aluOp, resultSrc;
    logic       adrSrc, irWrite, pcWrite, regWrite, memWrite, illegal;

    always #5 clk = ~clk;

    main_fsm dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
        .zero(zero), .memReady(memReady), .immSrc(immSrc), .aluSrcA(aluSrcA),
        .aluSrcB(aluSrcB), .aluOp(aluOp), .resultSrc(resultSrc), .adrSrc(adrSrc),
        .irWrite(irWrite), .pcWrite(pcWrite), .regWrite(regWrite),
        .memWrite(memWrite), .illegal(illegal)
    );

    // Phase kinds: plain fixed controls, FETCH (strobes follow memReady),
    // memory wait (hold until memReady), branch (pcWrite from zero), error.
    typedef enum logic [2:0] {K_PLAIN, K_FETCH, K_WAIT, K_BRANCH, K_ERR} kind_e;
    typedef struct packed {
        kind_e      kind;
        logic [1:0] a, b, op, res;
        logic       adr, pc, rw, mw;
    } step_t;

    step_t seq[$];
    int n_checks = 0, n_errors = 0;
    int ir_cnt, rw_cnt, mw_cnt, pc_cnt, cyc_cnt;
    logic went_err;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic [1:0] imm, a, b, op, res,
                                         input logic adr, ir, pc, rw, mw, ill);
        return {15'd0, imm, a, b, op, res, adr, ir, pc, rw, mw, ill};
    endfunction

    function automatic logic [31:0] actual();
        return pack(immSrc, aluSrcA, aluSrcB, aluOp, resultSrc,
                    adrSrc, irWrite, pcWrite, regWrite, memWrite, illegal);
    endfunction

    function automatic logic [1:0] imm_of(input logic [6:0] op);
        case (op)
            SW:      return 2'b01;
            BR:      return 2'b10;
            JAL:     return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // Under reset: FETCH selects, every strobe and illegal low
    function automatic logic [31:0] reset_vec();
        return pack(imm_of(opcode), 2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic step_t mk(input kind_e k, input logic [1:0] a, b, op, res,
                                 input logic adr, pc, rw, mw);
        step_t s;
        s.kind = k; s.a = a; s.b = b; s.op = op; s.res = res;
        s.adr = adr; s.pc = pc; s.rw = rw; s.mw = mw;
        return s;
    endfunction

    // Phase list of one instruction, from fetch to its last cycle
    task automatic build_seq(input logic [6:0] op, input logic [2:0] f3);
        step_t aluwb;
        aluwb = mk(K_PLAIN, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        seq.delete();
        seq.push_back(mk(K_FETCH, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0));
        seq.push_back(mk(K_PLAIN, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
        if (op == LW) begin
            seq.push_back(mk(K_PLAIN, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
            seq.push_back(mk(K_WAIT,  2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0));
            seq.push_back(mk(K_PLAIN, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0));
        end else if (op == SW) begin
            seq.push_back(mk(K_PLAIN, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
            seq.push_back(mk(K_WAIT,  2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1));
        end else if (op == RT) begin
            seq.push_back(mk(K_PLAIN, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
            seq.push_back(aluwb);
        end else if (op == IT) begin
            seq.push_back(mk(K_PLAIN, 2'b10, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
            seq.push_back(aluwb);
        end else if (op == JAL) begin
            seq.push_back(mk(K_PLAIN, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0));
            seq.push_back(aluwb);
        end else if (op == BR && (f3 == 3'b000 || f3 == 3'b001)) begin
            seq.push_back(mk(K_BRANCH, 2'b10, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
`ifdef JALR_EN
        end else if (op == JALR) begin
            seq.push_back(mk(K_PLAIN, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
            seq.push_back(mk(K_PLAIN, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0));
            seq.push_back(aluwb);
`endif
        end else begin
            seq.push_back(mk(K_ERR, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
        end
    endtask

    // One clock: drive memReady, compare at the falling edge, step past the rising edge
    task automatic do_cycle(input string tag, input logic mr, input step_t s);
        logic ir, pc;
        memReady = mr;
        @(negedge clk);
        ir = 1'b0;
        pc = s.pc;
        if (s.kind == K_FETCH) begin
            ir = mr;
            pc = mr;
        end
        if (s.kind == K_BRANCH) pc = (funct3 == 3'b000) ? zero : ~zero;
        check(tag, actual(), pack(imm_of(opcode), s.a, s.b, s.op, s.res, s.adr,
                                  ir, pc, s.rw, s.mw, s.kind == K_ERR));
        ir_cnt += int'(irWrite);
        rw_cnt += int'(regWrite);
        mw_cnt += int'(memWrite);
        pc_cnt += int'(pcWrite);
        cyc_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        ir_cnt = 0; rw_cnt = 0; mw_cnt = 0; pc_cnt = 0; cyc_cnt = 0;
    endtask

    // Run one instruction starting in FETCH; abort_at >= 0 asserts reset during that phase
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic z,
                             input int fw, input int mw, input int abort_at);
        string tag;
        opcode = op; funct3 = f3; zero = z;
        went_err = 1'b0;
        build_seq(op, f3);
        for (int i = 0; i < seq.size(); i++) begin
            tag = $sformatf("op%02h_f%0d_ph%0d", op, f3, i);
            if (i == abort_at) begin
                memReady = 1'b1;
                rst_n = 1'b0;
                #1;
                check({tag, "_rst"}, actual(), reset_vec());
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                return;
            end
            case (seq[i].kind)
                K_FETCH: for (int w = 0; w <= fw; w++) do_cycle(tag, w == fw, seq[i]);
                K_WAIT:  for (int w = 0; w <= mw; w++) do_cycle(tag, w == mw, seq[i]);
                K_ERR: begin
                    went_err = 1'b1;
                    for (int w = 0; w < 4; w++) do_cycle(tag, 1'($urandom), seq[i]);
                end
                default: do_cycle(tag, 1'($urandom), seq[i]);
            endcase
        end
    endtask

    // Reset pulse: strobes low even with memReady high, then back to FETCH
    task automatic do_reset(input string tag);
        memReady = 1'b1;
        rst_n = 1'b0;
        #1;
        check({tag, "_during"}, actual(), reset_vec());
        @(posedge clk);
        #1;
        check({tag, "_held"}, actual(), reset_vec());
        rst_n = 1'b1;
    endtask

    function automatic logic [6:0] rand_illegal();
        logic [6:0] o;
        do o = 7'($urandom);
        while (o == LW || o == SW || o == RT || o == IT || o == JAL || o == BR || o == JALR);
        return o;
    endfunction

    initial begin
        logic [6:0] op;
        logic [2:0] f3;
        int sel;

        rst_n = 1'b0; opcode = RT; funct3 = 3'b000; zero = 1'b0; memReady = 1'b1;
        #2;
        check("reset_init", actual(), reset_vec());
        repeat (2) @(posedge clk);
        #1;
        check("reset_init_held", actual(), reset_vec());
        rst_n = 1'b1;

        // lw with two FETCH and two MEMREAD wait cycles
        clear_counts();
        run_instr(LW, 3'b010, 1'b0, 2, 2, -1);
        check("lw_irwrite_pulses", ir_cnt, 1);
        check("lw_regwrite_cycles", rw_cnt, 1);
        check("lw_total_cycles", cyc_cnt, 9);

        // beq taken, bne not taken with zero=1
        clear_counts();
        run_instr(BR, 3'b000, 1'b1, 0, 0, -1);
        check("beq_pcwrite_count", pc_cnt, 2);
        clear_counts();
        run_instr(BR, 3'b001, 1'b1, 0, 0, -1);
        check("bne_pcwrite_count", pc_cnt, 1);

        // sw with three MEMWRITE wait cycles
        clear_counts();
        run_instr(SW, 3'b010, 1'b0, 0, 3, -1);
        check("sw_memwrite_cycles", mw_cnt, 4);

        // lui is unsupported: sticky error until reset
        clear_counts();
        run_instr(7'b0110111, 3'b000, 1'b0, 1, 0, -1);
        check("lui_pcwrite_count", pc_cnt, 1);
        check("lui_went_err", went_err, 1'b1);
        do_reset("lui_reset");
        run_instr(IT, 3'b000, 1'b0, 0, 0, -1);

        // reset asserted during EXECR, then a clean R-type from FETCH
        run_instr(RT, 3'b000, 1'b0, 0, 0, 2);
        run_instr(RT, 3'b111, 1'b1, 1, 0, -1);

        // jalr: three-state path when enabled, error otherwise
        run_instr(JALR, 3'b000, 1'b0, 0, 0, -1);
`ifdef JALR_EN
        check("jalr_no_err", went_err, 1'b0);
`else
        check("jalr_err", went_err, 1'b1);
`endif
        if (went_err) do_reset("jalr_reset");

        // randomized instruction stream
        for (int n = 0; n < 80; n++) begin
            sel = $urandom_range(0, 9);
            f3 = 3'($urandom);
            case (sel)
                0: op = LW;
                1: op = SW;
                2: op = RT;
                3: op = IT;
                4: op = JAL;
                5, 6: begin
                    op = BR;
                    if ($urandom_range(0, 4) != 0) f3 = {2'b00, 1'($urandom)};
                end
                7: op = JALR;
                8: op = ($urandom_range(0, 3) == 0) ? rand_illegal() : RT;
                default: op = IT;
            endcase
            run_instr(op, f3, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), -1);
            if (went_err) do_reset($sformatf("rand%0d_reset", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the run always ends on its own
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
